lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller: the initiator side of the data-memory port. It accepts one load or store request at a time from the core pipeline and drives the memory's `Wen`/`Ren`/`Adress`/`DataW` pins. It samples `DataR` to return load data, and performs read-modify-write for sub-word stores. It sits between the MIPS datapath (MEM stage) and the 256-word data memory.

## Interface
Parameters:
- `MEM_AW`, 8, word-index width; memory holds 2^MEM_AW 32-bit words.

Ports:
- `clk` in 1: the single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: core presents a request.
- `req_ready` out 1: controller accepts; request transfers when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: response available; held until taken.
- `rsp_ready` in 1: core takes the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned, out-of-range or illegal size.
- `Wen` out 1: memory write strobe.
- `Ren` out 1: memory read strobe.
- `Adress` out 32: memory word index, `{(32-MEM_AW)'b0, addr[MEM_AW+1:2]}`.
- `DataW` out 32: memory write data.
- `DataR` in 32: memory read data. The memory is combinational, so `DataR` is valid in the same cycle `Ren` is high.

## Operation
- States:
  - IDLE: `req_ready=1`.
  - RD: `Ren=1`.
  - WR: `Wen=1`.
  - RESP: `rsp_valid=1`.
- Request acceptance in IDLE latches addr, size, we, unsigned and wdata.
- Error check at acceptance:
  - `req_size==11` is an error.
  - Half with `addr[0]!=0` is an error.
  - Word with `addr[1:0]!=0` is an error.
  - `addr[31:MEM_AW+2]!=0` is an error.
  - On error go to RESP with `rsp_err=1`. No memory strobe is issued.
- Transitions:
  - Load: IDLE→RD→RESP. In RD, `DataR` is registered, the lane is extracted and extended into `rsp_rdata`.
  - Word store: IDLE→WR→RESP. `DataW = wdata`.
  - Byte/half store: IDLE→RD→WR→RESP.
    - RD captures the old word.
    - WR drives the merged word: new lane inserted, other bytes preserved.
  - RESP→IDLE when `rsp_ready=1`. Otherwise stay and hold all rsp outputs stable.
- Lanes are little-endian: byte k occupies bits [8k+7:8k], k = `addr[1:0]`. A half at `addr[1]` occupies [16·addr[1]+15:16·addr[1]].
- `Wen` and `Ren` are never high in the same cycle. The memory returns 0 in that case.
- `Wen`, `Ren`, `Adress` and `DataW` are driven from registers (glitch-free). `Adress`/`DataW` are stable for the whole cycle that `Wen` is high.
- Outside RD/WR: `Wen=Ren=0`. `Adress` and `DataW` hold their last values.

## Timing
- Reset: state=IDLE; `Wen=Ren=0`, `Adress=0`, `DataW=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`. `req_ready=0` while `rst=1`, and 1 the cycle after release.
- Latency, with request accepted in cycle 0:
  - Error: `rsp_valid` in cycle 1.
  - Load or word store: `rsp_valid` in cycle 2.
  - Sub-word store: `rsp_valid` in cycle 3.
- Throughput: one request outstanding. `req_ready=0` from cycle 1 until the cycle after the response is taken.
- Reset mid-operation wins over everything: the FSM returns to IDLE next edge and strobes drop. An interrupted RMW leaves memory either unmodified or fully written, never partial.
- `rsp_valid` with `rsp_ready` held high from cycle 0 lasts exactly one cycle.

## Structure
- `lsu_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`), state enum, `MEM_AW` default.
- One sub-module `lsu_lane_align` (combinational), with two functions:
  - extract + sign/zero-extend from a 32-bit word.
  - merge store lane into an old word.
- FSM and registers live in `lsu_ctrl`.
- Bench memory model: the existing data-memory module, instanced directly.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x10, then load word at 0x10. Expect `Adress=4`, one `Wen` cycle, and `rsp_rdata=0xDEADBEEF` at cycle 2.
- Byte store RMW: word at 0x20 = 0x11223344; store byte 0xAA at 0x22. Expect RD then WR with `DataW=0x11AA3344`, and `rsp_valid` at cycle 3.
- Sign/zero extension: word 0x0000F080 at 0x30.
  - Signed byte at 0x30 → 0xFFFFFF80.
  - Unsigned byte → 0x00000080.
  - Signed half → 0xFFFFF080.
- Errors, each giving `rsp_err=1` at cycle 1 with no `Wen`/`Ren` pulse:
  - Word load at 0x31.
  - Half store at 0x33.
  - Size 11.
  - Address 0x400.
- Backpressure: hold `rsp_ready=0` for 5 cycles. Response is stable, `req_ready=0`, and a new `req_valid` is not accepted. The response is taken on release.
- Reset during RMW: assert `rst` in the RD cycle of a byte store. Next cycle all outputs are at reset values and the memory word is unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states
// and the default data-memory word-index width.
package lsu_pkg;

    localparam int MEM_AW_DEF = 8;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling for the data port: pulls a byte/half/word lane
// out of a memory word (with sign or zero extension) and merges a store lane
// into an existing word for read-modify-write.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    // Select the addressed lane and extend it to 32 bits.
    function automatic logic [31:0] extract_ext(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (sz)
            SZ_B:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_H:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overwrite only the addressed lane; a full word store replaces everything.
    function automatic logic [31:0] merge_lane(
        input logic [31:0] old_word,
        input logic [1:0]  lo,
        input logic [1:0]  sz,
        input logic [31:0] wd
    );
        logic [31:0] r;
        r = old_word;
        case (sz)
            SZ_B:    r[{lo, 3'b000} +: 8]     = wd[7:0];
            SZ_H:    r[{lo[1], 4'b0000} +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    assign load_data   = extract_ext(rd_word, addr_lo, size, is_unsigned);
    assign merged_word = merge_lane(rd_word, addr_lo, size, wdata);

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one core request at a time and drives a
// combinational data memory. Sub-word stores are done as read-modify-write.
// All memory pins come straight from registers so they never glitch.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        Wen,
    output logic        Ren,
    output logic [31:0] Adress,
    output logic [31:0] DataW,
    input  logic [31:0] DataR
);

    lsu_state_e  state_q;
    logic        we_q;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic        wen_q;
    logic        ren_q;
    logic [31:0] adress_q;
    logic [31:0] dataw_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        req_err_d;
    logic [31:0] req_index_d;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // Reject illegal size, misalignment and anything beyond the memory depth.
    always_comb begin
        req_err_d = 1'b0;
        if (req_size == SZ_X)
            req_err_d = 1'b1;
        if (req_size == SZ_H && req_addr[0] != 1'b0)
            req_err_d = 1'b1;
        if (req_size == SZ_W && req_addr[1:0] != 2'b00)
            req_err_d = 1'b1;
        if (req_addr[31:MEM_AW+2] != '0)
            req_err_d = 1'b1;
    end

    assign req_index_d = {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};

    lsu_lane_align u_align (
        .rd_word     (DataR),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Control FSM plus every registered output of the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_lo_q   <= 2'b00;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            adress_q    <= '0;
            dataw_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        addr_lo_q   <= req_addr[1:0];
                        size_q      <= req_size;
                        uns_q       <= req_unsigned;
                        wdata_q     <= req_wdata;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= req_err_d;
                        if (req_err_d) begin
                            // Errors skip the memory entirely; pins keep old values.
                            state_q <= ST_RESP;
                        end else if (req_we && req_size == SZ_W) begin
                            adress_q <= req_index_d;
                            dataw_q  <= req_wdata;
                            wen_q    <= 1'b1;
                            state_q  <= ST_WR;
                        end else begin
                            // Loads and sub-word stores both need the current word.
                            adress_q <= req_index_d;
                            ren_q    <= 1'b1;
                            state_q  <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    ren_q <= 1'b0;
                    if (we_q) begin
                        dataw_q <= merged_word;
                        wen_q   <= 1'b1;
                        state_q <= ST_WR;
                    end else begin
                        rsp_rdata_q <= load_data;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    wen_q   <= 1'b0;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready)
                        state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign Wen       = wen_q;
    assign Ren       = ren_q;
    assign Adress    = adress_q;
    assign DataW     = dataw_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios followed by random
// requests, compared against a byte-arithmetic reference memory.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        Wen;
    logic        Ren;
    logic [31:0] Adress;
    logic [31:0] DataW;
    logic [31:0] DataR;

    int checks = 0;
    int errors = 0;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];

    logic [31:0] last_rdata;
    logic [31:0] last_dataw;
    logic [31:0] last_adr;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_AW(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .Wen          (Wen),
        .Ren          (Ren),
        .Adress       (Adress),
        .DataW        (DataW),
        .DataR        (DataR)
    );

    // Combinational-read data memory; a simultaneous Wen/Ren reads as zero.
    assign DataR = (Ren && !Wen) ? tb_mem[Adress[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (Wen && !Ren)
            tb_mem[Adress[7:0]] <= DataW;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout obs=running exp=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request with rsp_ready high and compare against the model.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] sz,
                           input logic uns, input logic [31:0] wd, input string tag);
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat, e_wen, e_ren;
        int          idx, sh, nb, lat, wen_c, ren_c, ovl, rdy_hi, w;
        logic [31:0] mask, val;
        nb   = 1 << sz;
        idx  = (addr >> 2) & 255;
        sh   = (addr & 3) * 8;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
        e_err = (sz == 2'b11) || ((addr % nb) != 0) || (addr >= 32'd1024);
        e_rdata = 32'h0;
        e_wen = 0;
        e_ren = 0;
        if (e_err) begin
            e_lat = 1;
        end else if (!we) begin
            e_lat = 2;
            e_ren = 1;
            val = (ref_mem[idx] >> sh) & mask;
            if (!uns && nb < 4 && val[8*nb-1])
                val = val | ~mask;
            e_rdata = val;
        end else begin
            e_wen = 1;
            e_ren = (nb == 4) ? 0 : 1;
            e_lat = (nb == 4) ? 2 : 3;
            ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = sz;
        req_unsigned = uns; req_wdata = wd; rsp_ready = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_accept"}, {31'b0, req_ready}, 32'd1);

        lat = 0; wen_c = 0; ren_c = 0; ovl = 0; rdy_hi = 0;
        do begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            wen_c += int'(Wen);
            ren_c += int'(Ren);
            if (Wen && Ren) ovl++;
            if (Wen) begin last_dataw = DataW; last_adr = Adress; end
            if (Ren) last_adr = Adress;
            if (req_ready) rdy_hi++;
        end while (!rsp_valid && lat < 10);

        last_rdata = rsp_rdata;
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_err"}, {31'b0, rsp_err}, {31'b0, e_err});
        check({tag, "_rdata"}, rsp_rdata, e_rdata);
        check({tag, "_wen_cycles"}, wen_c, e_wen);
        check({tag, "_ren_cycles"}, ren_c, e_ren);
        check({tag, "_strobe_overlap"}, ovl, 0);
        check({tag, "_ready_busy"}, rdy_hi, 0);
        if (!e_err)
            check({tag, "_adress"}, last_adr, idx);
        if (we && !e_err)
            check({tag, "_mem"}, tb_mem[idx], ref_mem[idx]);
        $display("txn %s we=%0d addr=%h sz=%0d uns=%0d wd=%h rdata=%h err=%0d lat=%0d",
                 tag, we, addr, sz, uns, wd, rsp_rdata, rsp_err, lat);
    endtask

    initial begin
        logic [31:0] bp_exp;
        logic [31:0] a;
        logic [1:0]  s;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end

        // Reset values
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_wen", {31'b0, Wen}, 32'd0);
        check("rst_ren", {31'b0, Ren}, 32'd0);
        check("rst_adress", Adress, 32'd0);
        check("rst_dataw", DataW, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", {31'b0, req_ready}, 32'd1);

        // Word store then load
        run_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, "word_store");
        check("word_store_adress4", last_adr, 32'd4);
        run_req(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, "word_load");
        check("word_load_value", last_rdata, 32'hDEADBEEF);

        // Byte store read-modify-write
        run_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h11223344, "rmw_init");
        run_req(1'b1, 32'h22, 2'b00, 1'b0, 32'h000000AA, "byte_store");
        check("byte_store_dataw", last_dataw, 32'h11AA3344);

        // Sign / zero extension
        run_req(1'b1, 32'h30, 2'b10, 1'b0, 32'h0000F080, "ext_init");
        run_req(1'b0, 32'h30, 2'b00, 1'b0, 32'h0, "ld_sbyte");
        check("ld_sbyte_value", last_rdata, 32'hFFFFFF80);
        run_req(1'b0, 32'h30, 2'b00, 1'b1, 32'h0, "ld_ubyte");
        check("ld_ubyte_value", last_rdata, 32'h00000080);
        run_req(1'b0, 32'h30, 2'b01, 1'b0, 32'h0, "ld_shalf");
        check("ld_shalf_value", last_rdata, 32'hFFFFF080);

        // Error cases
        run_req(1'b0, 32'h31, 2'b10, 1'b0, 32'h0, "err_misword");
        run_req(1'b1, 32'h33, 2'b01, 1'b0, 32'h1234, "err_mishalf");
        run_req(1'b0, 32'h30, 2'b11, 1'b0, 32'h0, "err_size");
        run_req(1'b0, 32'h400, 2'b10, 1'b0, 32'h0, "err_range");

        // Backpressure: response held while rsp_ready is low
        bp_exp = ref_mem[4];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10;
        req_unsigned = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_first_valid", {31'b0, rsp_valid}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'b10;
        req_wdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_hold_rdata", rsp_rdata, bp_exp);
            check("bp_hold_err", {31'b0, rsp_err}, 32'd0);
            check("bp_hold_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("bp_taken_valid", {31'b0, rsp_valid}, 32'd0);
        check("bp_taken_ready", {31'b0, req_ready}, 32'd1);
        check("bp_no_accept", {30'b0, Wen, Ren}, 32'd0);
        check("bp_mem_intact", tb_mem[4], ref_mem[4]);
        $display("txn backpressure rdata=%h held=5", bp_exp);

        // Reset in the RD cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h24; req_size = 2'b00;
        req_wdata = 32'h55;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstrmw_in_rd", {31'b0, Ren}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rstrmw_wen", {31'b0, Wen}, 32'd0);
        check("rstrmw_ren", {31'b0, Ren}, 32'd0);
        check("rstrmw_adress", Adress, 32'd0);
        check("rstrmw_dataw", DataW, 32'd0);
        check("rstrmw_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rstrmw_rsp_rdata", rsp_rdata, 32'd0);
        check("rstrmw_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rstrmw_req_ready", {31'b0, req_ready}, 32'd0);
        check("rstrmw_mem", tb_mem[9], ref_mem[9]);
        rst = 1'b0;
        @(negedge clk);
        check("rstrmw_ready_after", {31'b0, req_ready}, 32'd1);
        check("rstrmw_mem_after", tb_mem[9], ref_mem[9]);
        $display("txn reset_during_rmw mem[9]=%h", tb_mem[9]);

        // Random traffic over a small window so loads see earlier stores
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                a = 32'h400 + $urandom_range(0, 63);
            else
                a = $urandom_range(0, 63);
            s = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && s != 2'b11)
                a = a & ~((32'h1 << s) - 1);
            run_req(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
